hwo_subst_ctrl: RTL

- Sequencer for the instruction obfuscation datapath. It sits between the decode-stage instruction (id_insn) and the obfuscated instruction output (io_insn).
- Non-matching instructions pass through with one cycle of latency.
- When the external matcher flags an instruction, the block consumes it and stalls upstream. It then replays an equivalent substitute sequence from a synchronous substitution ROM, one instruction per cycle, honouring downstream stall.

---
 rtl/hwo_subst_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/hwo_subst_ctrl.sv
// Instruction substitution sequencer: forwards decode-stage instructions with one cycle of latency,
// or swaps a matched instruction for a replacement sequence replayed from a synchronous ROM.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pass-through; a matched instruction is accepted here
// READ  | first ROM read in flight; a bubble goes out on io
// ISSUE | one substitute per unstalled cycle until cnt reaches 1
module hwo_subst_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter int          LEN_W    = 4,
  parameter logic [31:0] NOP_INSN = 32'h1500_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              obf_en,
  input  logic [31:0]       id_insn,
  input  logic              id_valid,
  output logic              id_stall,
  input  logic              sub_match,
  input  logic [ADDR_W-1:0] sub_base,
  input  logic [LEN_W-1:0]  sub_len,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              ex_stall,
  output logic [31:0]       io_insn,
  output logic              io_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       io_insn_nxt;
  logic              io_valid_nxt;
  logic [ADDR_W-1:0] rom_addr_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              hit;

  // A zero-length sequence has nothing to replay, so it falls through as a plain instruction.
  assign hit      = id_valid & obf_en & sub_match & (sub_len != '0);
  assign busy     = (state != IDLE);
  assign id_stall = ex_stall | busy;
  assign rom_en   = (state == READ) | ((state == ISSUE) & ~ex_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      io_insn  <= NOP_INSN;
      io_valid <= 1'b0;
      rom_addr <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      io_insn  <= io_insn_nxt;
      io_valid <= io_valid_nxt;
      rom_addr <= rom_addr_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    io_insn_nxt  = io_insn;
    io_valid_nxt = io_valid;
    rom_addr_nxt = rom_addr;
    cnt_nxt      = cnt;
    if (!ex_stall) begin
      case (state)
        IDLE: begin
          if (hit) begin
            rom_addr_nxt = sub_base;
            cnt_nxt      = sub_len;
            io_insn_nxt  = NOP_INSN;
            io_valid_nxt = 1'b0;
            state_nxt    = READ;
          end else begin
            io_insn_nxt  = id_insn;
            io_valid_nxt = id_valid;
          end
        end
        READ: begin
          rom_addr_nxt = rom_addr + ADDR_W'(1);
          io_insn_nxt  = NOP_INSN;
          io_valid_nxt = 1'b0;
          state_nxt    = ISSUE;
        end
        ISSUE: begin
          // rom_data already holds the word addressed one cycle earlier.
          io_insn_nxt  = rom_data;
          io_valid_nxt = 1'b1;
          rom_addr_nxt = rom_addr + ADDR_W'(1);
          if (cnt <= LEN_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
